// File: rtl/popcount_accumulator.sv
// Two-stage popcount accumulator: stage 1 counts the set bits of a beat, stage 2 sums
// the counts over a group and hands the total to a valid/ready output register.
module popcount_accumulator #(
  parameter  int WIDTH     = 8,
  parameter  int MAX_BEATS = 4,
  localparam int SUM_W     = $clog2(WIDTH*MAX_BEATS+1),
  localparam int CNT_W     = $clog2(WIDTH+1),
  localparam int BEAT_W    = $clog2(MAX_BEATS+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in_bits,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              clear,
  output logic [SUM_W-1:0]  out_sum,
  output logic [BEAT_W-1:0] out_beats,
  output logic              out_ovf,
  output logic              out_valid,
  input  logic              out_ready
);

  logic              advance;
  logic [CNT_W-1:0]  beat_cnt;

  logic              s1_valid;
  logic [CNT_W-1:0]  s1_cnt;
  logic              s1_last;

  logic [SUM_W-1:0]  acc;
  logic [BEAT_W-1:0] beats;
  logic              grp_ovf;

  logic [SUM_W:0]    acc_wide;
  logic [SUM_W-1:0]  acc_sat;
  logic              at_max;
  logic [BEAT_W-1:0] beats_next;
  logic              ovf_next;
  logic              complete;

  // The whole pipeline freezes only while a finished result waits for its consumer.
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  always_comb begin
    beat_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      beat_cnt = beat_cnt + CNT_W'(in_bits[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_cnt   <= '0;
      s1_last  <= 1'b0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_cnt   <= in_valid ? beat_cnt : '0;
      s1_last  <= in_valid && in_last;
    end
  end

  // One extra bit on the sum exposes overflow; beat overflow is a count already at MAX_BEATS.
  always_comb begin
    acc_wide   = {1'b0, acc} + (SUM_W+1)'(s1_cnt);
    acc_sat    = acc_wide[SUM_W] ? '1 : acc_wide[SUM_W-1:0];
    at_max     = (beats == BEAT_W'(MAX_BEATS));
    beats_next = at_max ? beats : beats + BEAT_W'(1);
    ovf_next   = grp_ovf || acc_wide[SUM_W] || at_max;
    complete   = s1_valid && s1_last && !clear;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      beats   <= '0;
      grp_ovf <= 1'b0;
    end else if (advance) begin
      if (clear || complete) begin
        acc     <= '0;
        beats   <= '0;
        grp_ovf <= 1'b0;
      end else if (s1_valid) begin
        acc     <= acc_sat;
        beats   <= beats_next;
        grp_ovf <= ovf_next;
      end
    end
  end

  // A new completion may overwrite a result on the same edge it is being consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_beats <= '0;
      out_ovf   <= 1'b0;
    end else if (advance) begin
      out_valid <= complete;
      if (complete) begin
        out_sum   <= acc_sat;
        out_beats <= beats_next;
        out_ovf   <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_popcount_accumulator.sv
// Scoreboard bench for popcount_accumulator: a group-level reference model queues the
// expected results and an independent monitor checks each result the DUT hands over.
module tb_popcount_accumulator;

  localparam int WIDTH     = 8;
  localparam int MAX_BEATS = 4;
  localparam int SUM_W     = $clog2(WIDTH*MAX_BEATS+1);
  localparam int BEAT_W    = $clog2(MAX_BEATS+1);
  localparam int SUM_MAX   = (1 << SUM_W) - 1;

  typedef struct {
    int sum;
    int beats;
    int ovf;
  } result_t;

  logic              clk;
  logic              reset;
  logic [WIDTH-1:0]  in_bits;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic              clear;
  logic [SUM_W-1:0]  out_sum;
  logic [BEAT_W-1:0] out_beats;
  logic              out_ovf;
  logic              out_valid;
  logic              out_ready;

  int vectors     = 0;
  int miscompares = 0;

  result_t exp_q[$];

  // Group-level model: the open group is a running total and beat count; a group whose
  // last beat was just accepted waits one accepting edge, where a clear can still kill it.
  int open_sum   = 0;
  int open_n     = 0;
  bit pend_valid = 0;
  int pend_sum   = 0;
  int pend_n     = 0;

  popcount_accumulator #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_bits  (in_bits),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .clear    (clear),
    .out_sum  (out_sum),
    .out_beats(out_beats),
    .out_ovf  (out_ovf),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic result_t make_result(input int total, input int n);
    result_t r;
    r.sum   = (total > SUM_MAX) ? SUM_MAX : total;
    r.beats = (n > MAX_BEATS) ? MAX_BEATS : n;
    r.ovf   = ((n > MAX_BEATS) || (total > SUM_MAX)) ? 1 : 0;
    return r;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic model_clear();
    open_sum   = 0;
    open_n     = 0;
    pend_valid = 0;
    exp_q.delete();
  endtask

  // Drives one cycle of inputs, notes whether the DUT will accept at the coming edge,
  // then advances the reference model at that edge.
  task automatic applyStimulus(input bit v, input logic [WIDTH-1:0] bits, input bit last,
                               input bit clr, input bit ordy, output bit accepted);
    bit adv;
    @(negedge clk);
    in_valid  = v;
    in_bits   = bits;
    in_last   = last;
    clear     = clr;
    out_ready = ordy;
    #1;
    adv = in_ready;
    @(posedge clk);
    if (adv) begin
      if (pend_valid && !clr) exp_q.push_back(make_result(pend_sum, pend_n));
      pend_valid = 0;
      if (clr) begin
        open_sum = 0;
        open_n   = 0;
      end
      if (v) begin
        open_sum += $countones(bits);
        open_n++;
        if (last) begin
          pend_valid = 1;
          pend_sum   = open_sum;
          pend_n     = open_n;
          open_sum   = 0;
          open_n     = 0;
        end
      end
    end
    accepted = adv && v;
  endtask

  task automatic idle(input int n, input bit ordy);
    bit a;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, ordy, a);
  endtask

  task automatic send(input logic [WIDTH-1:0] bits, input bit last, input bit clr);
    bit a;
    applyStimulus(1'b1, bits, last, clr, 1'b1, a);
    checkOutput("send_accept", int'(a), 1);
  endtask

  // Asserts reset between edges and checks that everything drops before the next edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    checkOutput({tag, "_out_valid"}, int'(out_valid), 0);
    checkOutput({tag, "_out_sum"}, int'(out_sum), 0);
    checkOutput({tag, "_out_beats"}, int'(out_beats), 0);
    checkOutput({tag, "_out_ovf"}, int'(out_ovf), 0);
    checkOutput({tag, "_in_ready"}, int'(in_ready), 1);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: each handshake the DUT completes is popped from the scoreboard and compared.
  initial begin
    result_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_result: got sum %0d beats %0d, expected no result",
                   out_sum, out_beats);
        end else begin
          e = exp_q.pop_front();
          checkOutput("out_sum", int'(out_sum), e.sum);
          checkOutput("out_beats", int'(out_beats), e.beats);
          checkOutput("out_ovf", int'(out_ovf), e.ovf);
        end
      end
    end
  end

  // Directed scenarios first, then randomized traffic, then a bounded drain.
  initial begin
    bit a;
    bit hv;
    bit hl;
    bit clr;
    bit ordy;
    logic [WIDTH-1:0] hb;
    int budget;

    reset     = 1'b1;
    in_bits   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;
    #3;
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out_sum", int'(out_sum), 0);
    checkOutput("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] single beat and latency");
    send(8'hFF, 1'b1, 1'b0);
    #1 checkOutput("latency_edge1_valid", int'(out_valid), 0);
    idle(1, 1'b1);
    #1 checkOutput("latency_edge2_valid", int'(out_valid), 1);
    idle(2, 1'b1);

    $display("[TB] three-beat group then back-to-back group");
    send(8'h01, 1'b0, 1'b0);
    send(8'h0F, 1'b0, 1'b0);
    send(8'hA5, 1'b1, 1'b0);
    send(8'h03, 1'b1, 1'b0);
    idle(3, 1'b1);

    $display("[TB] output stall");
    send(8'hFF, 1'b1, 1'b0);
    idle(2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, a);
      checkOutput("stall_no_accept", int'(a), 0);
    end
    #1 checkOutput("stall_in_ready", int'(in_ready), 0);
    a = 1'b0;
    for (int i = 0; i < 5 && !a; i++) applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, a);
    checkOutput("stall_release_accept", int'(a), 1);
    send(8'h22, 1'b1, 1'b0);
    idle(3, 1'b1);

    $display("[TB] beat overflow and sum saturation");
    for (int i = 0; i < 6; i++) send(8'hFF, i == 5, 1'b0);
    for (int i = 0; i < 8; i++) send(8'hFF, i == 7, 1'b0);
    idle(3, 1'b1);

    $display("[TB] clear");
    send(8'hFF, 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b0);
    send(8'h01, 1'b1, 1'b1);
    idle(3, 1'b1);

    $display("[TB] reset mid-group and mid-stall");
    send(8'hFF, 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b0);
    async_reset("rst_mid_group");
    send(8'h80, 1'b1, 1'b0);
    idle(3, 1'b1);
    send(8'h0F, 1'b1, 1'b0);
    idle(2, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, a);
    async_reset("rst_mid_stall");
    send(8'h80, 1'b1, 1'b0);
    idle(3, 1'b1);

    $display("[TB] random traffic");
    hv = 1'b0;
    hb = '0;
    hl = 1'b0;
    for (int k = 0; k < 800; k++) begin
      if (!hv) begin
        hv = ($urandom_range(0, 3) != 0);
        hb = WIDTH'($urandom);
        hl = ($urandom_range(0, 3) == 0);
      end
      clr  = ($urandom_range(0, 19) == 0);
      ordy = ($urandom_range(0, 9) < 7);
      applyStimulus(hv, hb, hl, clr, ordy, a);
      if (a) hv = 1'b0;
    end

    budget = 0;
    while ((exp_q.size() != 0 || pend_valid) && budget < 50) begin
      idle(1, 1'b1);
      budget++;
    end
    idle(3, 1'b1);
    checkOutput("drain_pending_results", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
